// File: rtl/branch_resolver.sv
// EX-stage branch resolution unit: resolves each control transfer, publishes a one-entry
// record for the predictor and squashes wrong-path EX instructions after a mispredict.
// Optional performance counters are enabled with `define BRANCH_PERF_EN.
module branch_resolver #(
  parameter int unsigned SHADOW_CYCLES = 1,
  parameter int unsigned CNT_WIDTH     = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 stall,
  input  logic                 ex_valid,
  input  logic                 ex_branch,
  input  logic                 ex_cond,
  input  logic                 ex_jalr,
  input  logic [2:0]           ex_funct3,
  input  logic [31:0]          ex_pc,
  input  logic [31:0]          ex_imm,
  input  logic [31:0]          ex_rs1_val,
  input  logic [31:0]          ex_rs2_val,
  input  logic                 ex_predict_taken,
  input  logic [31:0]          ex_predict_pc,
  output logic [31:0]          old_pc,
  output logic [31:0]          old_branch_pc,
  output logic [31:0]          old_predict_pc,
  output logic                 old_predict,
  output logic                 old_actual,
  output logic                 old_branch,
  output logic [CNT_WIDTH-1:0] branch_cnt,
  output logic [CNT_WIDTH-1:0] miss_cnt,
  output logic [1:0]           dbg_state
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    REC_OK   = 2'd1,
    REC_MISS = 2'd2,
    SHADOW   = 2'd3
  } state_t;

  localparam logic [2:0] SHADOW_LOAD = (SHADOW_CYCLES == 0) ? 3'd0 : 3'(SHADOW_CYCLES - 1);

  state_t      state_q, state_d;
  logic [2:0]  shadow_q, shadow_d;
  logic        cond_true, actual, ex_miss;
  logic        capture_ok, capture;
  logic [31:0] jalr_sum, target, next_pc;

  always_comb begin
    cond_true = 1'b0;
    case (ex_funct3)
      3'b000:  cond_true = (ex_rs1_val == ex_rs2_val);
      3'b001:  cond_true = (ex_rs1_val != ex_rs2_val);
      3'b100:  cond_true = ($signed(ex_rs1_val) <  $signed(ex_rs2_val));
      3'b101:  cond_true = ($signed(ex_rs1_val) >= $signed(ex_rs2_val));
      3'b110:  cond_true = (ex_rs1_val <  ex_rs2_val);
      3'b111:  cond_true = (ex_rs1_val >= ex_rs2_val);
      default: cond_true = 1'b0;
    endcase
  end

  assign actual   = ex_cond ? cond_true : 1'b1;
  assign jalr_sum = ex_rs1_val + ex_imm;
  assign target   = ex_jalr ? {jalr_sum[31:1], 1'b0} : (ex_pc + ex_imm);
  assign next_pc  = actual ? target : (ex_pc + 32'd4);
  // Same rule the predictor applies to the published record.
  assign ex_miss  = (actual != ex_predict_taken) || (next_pc != ex_predict_pc);

  always_comb begin
    state_d    = state_q;
    shadow_d   = shadow_q;
    capture_ok = 1'b0;
    case (state_q)
      IDLE, REC_OK: capture_ok = 1'b1;
      REC_MISS: begin
        if (SHADOW_CYCLES == 0) begin
          capture_ok = 1'b1;
        end else begin
          shadow_d = SHADOW_LOAD;
          state_d  = (SHADOW_LOAD != 3'd0) ? SHADOW : IDLE;
        end
      end
      SHADOW: begin
        shadow_d = (shadow_q == 3'd0) ? 3'd0 : (shadow_q - 3'd1);
        state_d  = (shadow_q <= 3'd1) ? IDLE : SHADOW;
      end
      default: state_d = IDLE;
    endcase
    capture = capture_ok && (shadow_q == 3'd0) && ex_valid && ex_branch;
    if (capture_ok) begin
      state_d = capture ? (ex_miss ? REC_MISS : REC_OK) : IDLE;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q        <= IDLE;
      shadow_q       <= 3'd0;
      old_branch     <= 1'b0;
      old_actual     <= 1'b0;
      old_predict    <= 1'b0;
      old_pc         <= 32'd0;
      old_branch_pc  <= 32'd0;
      old_predict_pc <= 32'd0;
    end else if (!stall) begin
      state_q  <= state_d;
      shadow_q <= shadow_d;
      // A non-captured cycle clears the record so the predictor never sees a stale fail.
      old_branch     <= capture;
      old_actual     <= capture ? actual : 1'b0;
      old_predict    <= capture ? ex_predict_taken : 1'b0;
      old_pc         <= capture ? next_pc : 32'd0;
      old_branch_pc  <= capture ? ex_pc : 32'd0;
      old_predict_pc <= capture ? ex_predict_pc : 32'd0;
    end
  end

  assign dbg_state = state_q;

`ifdef BRANCH_PERF_EN
  logic [CNT_WIDTH-1:0] branch_q, miss_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      branch_q <= '0;
      miss_q   <= '0;
    end else if (!stall && capture) begin
      if (branch_q != '1) branch_q <= branch_q + CNT_WIDTH'(1);
      if (ex_miss && (miss_q != '1)) miss_q <= miss_q + CNT_WIDTH'(1);
    end
  end

  assign branch_cnt = branch_q;
  assign miss_cnt   = miss_q;
`else
  assign branch_cnt = '0;
  assign miss_cnt   = '0;
`endif

endmodule
